motoro3_ramp_ctrl: RTL and testbench

Speed/direction sequencer that drives the command inputs (m3start, m3invOrStop, m3freq) of the 3-phase motor top. It accepts run/direction/speed commands over a valid/ready handshake and ramps m3freq one code per step interval toward the target. Direction reversal is always decel → dead pause → flip → accel; it never flips while energised. A fault input forces immediate de-energise.

---
 rtl/motoro3_ramp_ctrl_pkg.sv | 47 ++++
 rtl/motoro3_ramp_ctrl_if.sv | 15 +
 rtl/motoro3_ramp_ctrl_step_tick.sv | 40 ++++
 rtl/motoro3_ramp_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_motoro3_ramp_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/motoro3_ramp_ctrl_pkg.sv
// Shared state encoding, default speed-code limits and code helpers
// for the motoro3 ramp controller.
package motoro3_pkg;

   localparam int CODE_W = 10;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ACCEL = 3'd1,
      ST_RUN   = 3'd2,
      ST_DECEL = 3'd3,
      ST_PAUSE = 3'd4
   } state_e;

   localparam logic [CODE_W-1:0] CODE_MIN_DEF  = 10'd1000;
   localparam logic [CODE_W-1:0] CODE_MAX_DEF  = 10'd1023;
   localparam logic [CODE_W-1:0] REST_CODE_DEF = 10'd1023;

   function automatic logic [CODE_W-1:0] clamp_code(input logic [CODE_W-1:0] code,
                                                    input logic [CODE_W-1:0] lo,
                                                    input logic [CODE_W-1:0] hi);
      logic [CODE_W-1:0] r;
      if (code < lo) begin
         r = lo;
      end else if (code > hi) begin
         r = hi;
      end else begin
         r = code;
      end
      return r;
   endfunction

   // One code toward the goal, or hold when already there.
   function automatic logic [CODE_W-1:0] step_toward(input logic [CODE_W-1:0] cur,
                                                     input logic [CODE_W-1:0] goal);
      logic [CODE_W-1:0] r;
      if (cur < goal) begin
         r = cur + 10'd1;
      end else if (cur > goal) begin
         r = cur - 10'd1;
      end else begin
         r = cur;
      end
      return r;
   endfunction

endpackage

// File: rtl/motoro3_ramp_ctrl_if.sv
// Command channel of the ramp controller: valid/ready plus run/dir/code payload.
interface motoro3_ramp_ctrl_if;
   import motoro3_pkg::*;

   logic              cmd_valid;
   logic              cmd_ready;
   logic              cmd_run;
   logic              cmd_dir;
   logic [CODE_W-1:0] cmd_code;

   modport master (output cmd_valid, output cmd_run, output cmd_dir, output cmd_code,
                   input  cmd_ready);
   modport slave  (input  cmd_valid, input  cmd_run, input  cmd_dir, input  cmd_code,
                   output cmd_ready);
endinterface

// File: rtl/motoro3_ramp_ctrl_step_tick.sv
// Ramp-rate divider: one-cycle tick every DIV clocks, restarted by clr_i.
module motoro3_step_tick
   import motoro3_pkg::*;
#(
   parameter int DIV   = 1000,
   parameter int CNT_W = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clr_i,
   output logic tick_o
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Next count: wrap at LAST, restart on clear.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i || (cnt_q == LAST)) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // Counter register.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/motoro3_ramp_ctrl.sv
// Speed/direction sequencer for the 3-phase motor top: ramps m3freq toward the
// commanded code and only reverses after a decel to rest and a dead pause.
module motoro3_ramp_ctrl
   import motoro3_pkg::*;
#(
   parameter logic [CODE_W-1:0] CODE_MIN  = CODE_MIN_DEF,
   parameter logic [CODE_W-1:0] CODE_MAX  = CODE_MAX_DEF,
   parameter logic [CODE_W-1:0] REST_CODE = REST_CODE_DEF,
   parameter int                STEP_DIV  = 1000,
   parameter int                PAUSE_CYC = 10000,
   parameter int                CNT_W     = 16
) (
   input  logic              clk,
   input  logic              rst,
   motoro3_ramp_ctrl_if.slave cmd,
   input  logic              fault,
   input  logic              fault_clr,
   output logic              m3start,
   output logic              m3invOrStop,
   output logic [CODE_W-1:0] m3freq,
   output logic              at_speed,
   output logic              busy,
   output logic              fault_latched,
   output logic [2:0]        state_o
);

   state_e            state_q, state_d;
   logic              run_q, run_d, dir_q, dir_d;
   logic [CODE_W-1:0] tgt_q, tgt_d, freq_q, freq_d;
   logic              start_q, start_d, inv_q, inv_d, flt_q, flt_d;
   logic [CNT_W-1:0]  pause_q, pause_d;
   logic              ready_s, accept_s, tick_s, clr_s;
   logic [CODE_W-1:0] accel_next_s, decel_next_s;

   assign ready_s  = !rst && !flt_q && !fault &&
                     ((state_q == ST_IDLE) || (state_q == ST_ACCEL) || (state_q == ST_RUN));
   assign accept_s = cmd.cmd_valid && ready_s;
   assign cmd.cmd_ready = ready_s;

   // Any state change restarts the step divider so the first step lands STEP_DIV clocks in.
   assign clr_s = (state_d != state_q);

   motoro3_step_tick #(.DIV(STEP_DIV), .CNT_W(CNT_W)) u_tick (
      .clk    (clk),
      .rst    (rst),
      .clr_i  (clr_s),
      .tick_o (tick_s)
   );

   assign accel_next_s = tick_s ? step_toward(freq_q, tgt_q) : freq_q;
   assign decel_next_s = tick_s ? step_toward(freq_q, REST_CODE) : freq_q;

   // Command capture, fault latch and sequencer next state.
   always_comb begin
      state_d = state_q;
      run_d   = run_q;
      dir_d   = dir_q;
      tgt_d   = tgt_q;
      freq_d  = freq_q;
      start_d = start_q;
      inv_d   = inv_q;
      pause_d = pause_q;
      flt_d   = flt_q;

      if (accept_s) begin
         run_d = cmd.cmd_run;
         dir_d = cmd.cmd_dir;
         tgt_d = clamp_code(cmd.cmd_code, CODE_MIN, CODE_MAX);
      end else begin
         tgt_d = tgt_q;
      end

      if (fault) begin
         flt_d = 1'b1;
      end else if (fault_clr) begin
         flt_d = 1'b0;
      end else begin
         flt_d = flt_q;
      end

      if (fault) begin
         state_d = ST_IDLE;
         start_d = 1'b0;
         freq_d  = REST_CODE;
         pause_d = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (accept_s && cmd.cmd_run) begin
                  start_d = 1'b1;
                  inv_d   = cmd.cmd_dir;
                  freq_d  = REST_CODE;
                  state_d = ST_ACCEL;
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_ACCEL: begin
               // Stop or reversal aborts the accel; the direction never flips while energised.
               if (accept_s && (!cmd.cmd_run || (cmd.cmd_dir != inv_q))) begin
                  state_d = ST_DECEL;
               end else begin
                  freq_d = accel_next_s;
                  if (!accept_s && (accel_next_s == tgt_q)) begin
                     state_d = ST_RUN;
                  end else begin
                     state_d = ST_ACCEL;
                  end
               end
            end
            ST_RUN: begin
               if (accept_s && cmd.cmd_run && (cmd.cmd_dir == inv_q)) begin
                  state_d = ST_ACCEL;
               end else if (accept_s) begin
                  state_d = ST_DECEL;
               end else begin
                  state_d = ST_RUN;
               end
            end
            ST_DECEL: begin
               freq_d = decel_next_s;
               if (decel_next_s == REST_CODE) begin
                  start_d = 1'b0;
                  pause_d = '0;
                  state_d = run_q ? ST_PAUSE : ST_IDLE;
               end else begin
                  state_d = ST_DECEL;
               end
            end
            ST_PAUSE: begin
               if (pause_q == CNT_W'(PAUSE_CYC - 1)) begin
                  start_d = 1'b1;
                  inv_d   = dir_q;
                  freq_d  = REST_CODE;
                  pause_d = '0;
                  state_d = ST_ACCEL;
               end else begin
                  pause_d = pause_q + CNT_W'(1);
                  state_d = ST_PAUSE;
               end
            end
            default: begin
               state_d = ST_IDLE;
               start_d = 1'b0;
               freq_d  = REST_CODE;
               pause_d = '0;
            end
         endcase
      end
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         run_q   <= 1'b0;
         dir_q   <= 1'b0;
         tgt_q   <= REST_CODE;
         freq_q  <= REST_CODE;
         start_q <= 1'b0;
         inv_q   <= 1'b0;
         pause_q <= '0;
         flt_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         run_q   <= run_d;
         dir_q   <= dir_d;
         tgt_q   <= tgt_d;
         freq_q  <= freq_d;
         start_q <= start_d;
         inv_q   <= inv_d;
         pause_q <= pause_d;
         flt_q   <= flt_d;
      end
   end

   assign m3start       = start_q;
   assign m3invOrStop   = inv_q;
   assign m3freq        = freq_q;
   assign at_speed      = (state_q == ST_RUN);
   assign busy          = (state_q != ST_IDLE);
   assign fault_latched = flt_q;
   assign state_o       = state_q;

endmodule

// File: tb/tb_motoro3_ramp_ctrl.sv
// Directed bench for motoro3_ramp_ctrl with STEP_DIV=4, PAUSE_CYC=8.
module tb_motoro3_ramp_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       fault;
   logic       fault_clr;
   logic       m3start;
   logic       m3invOrStop;
   logic [9:0] m3freq;
   logic       at_speed;
   logic       busy;
   logic       fault_latched;
   logic [2:0] state_o;

   int n_checks = 0;
   int n_fail   = 0;

   motoro3_ramp_ctrl_if cmd_if ();

   motoro3_ramp_ctrl #(.STEP_DIV(4), .PAUSE_CYC(8)) dut (
      .clk           (clk),
      .rst           (rst),
      .cmd           (cmd_if),
      .fault         (fault),
      .fault_clr     (fault_clr),
      .m3start       (m3start),
      .m3invOrStop   (m3invOrStop),
      .m3freq        (m3freq),
      .at_speed      (at_speed),
      .busy          (busy),
      .fault_latched (fault_latched),
      .state_o       (state_o)
   );

   always #50 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Present one command for exactly one clock edge.
   task automatic send(input logic run, input logic dir, input logic [9:0] code);
      cmd_if.cmd_valid = 1'b1;
      cmd_if.cmd_run   = run;
      cmd_if.cmd_dir   = dir;
      cmd_if.cmd_code  = code;
      cyc();
      cmd_if.cmd_valid = 1'b0;
   endtask

   task automatic test_reset();
      logic [17:0] got;
      rst = 1'b1; fault = 1'b0; fault_clr = 1'b0;
      cmd_if.cmd_valid = 1'b0; cmd_if.cmd_run = 1'b0; cmd_if.cmd_dir = 1'b0; cmd_if.cmd_code = 10'd0;
      cyc();
      cyc();
      n_checks++;
      if (cmd_if.cmd_ready !== 1'b0) begin
         n_fail++; $display("FAIL reset_ready: got %b want 0", cmd_if.cmd_ready);
      end
      got = {m3start, m3invOrStop, m3freq, at_speed, busy, fault_latched, state_o};
      n_checks++;
      if (got !== {1'b0, 1'b0, 10'd1023, 1'b0, 1'b0, 1'b0, 3'd0}) begin
         n_fail++; $display("FAIL reset_outputs: got %h want %h", got, {1'b0, 1'b0, 10'd1023, 1'b0, 1'b0, 1'b0, 3'd0});
      end
      rst = 1'b0;
      #1;
      n_checks++;
      if (cmd_if.cmd_ready !== 1'b1) begin
         n_fail++; $display("FAIL idle_ready: got %b want 1", cmd_if.cmd_ready);
      end
   endtask

   task automatic test_accel();
      logic [9:0] exp_f;
      logic       exp_a;
      send(1'b1, 1'b0, 10'd1010);
      n_checks++;
      if ({m3start, m3invOrStop, m3freq, state_o, busy} !== {1'b1, 1'b0, 10'd1023, 3'd1, 1'b1}) begin
         n_fail++; $display("FAIL accel_start: got %b %b %0d %0d %b want 1 0 1023 1 1", m3start, m3invOrStop, m3freq, state_o, busy);
      end
      for (int i = 1; i <= 52; i++) begin
         cyc();
         exp_f = 10'(1023 - i / 4);
         exp_a = (i == 52);
         n_checks++;
         if (m3freq !== exp_f) begin
            n_fail++; $display("FAIL accel_freq cyc %0d: got %0d want %0d", i, m3freq, exp_f);
         end
         n_checks++;
         if (at_speed !== exp_a) begin
            n_fail++; $display("FAIL accel_at_speed cyc %0d: got %b want %b", i, at_speed, exp_a);
         end
      end
   endtask

   task automatic test_clamp();
      logic [9:0] exp_f;
      logic       exp_a;
      send(1'b1, 1'b0, 10'd900);
      n_checks++;
      if ({at_speed, state_o, m3freq} !== {1'b0, 3'd1, 10'd1010}) begin
         n_fail++; $display("FAIL clamp_entry: got %b %0d %0d want 0 1 1010", at_speed, state_o, m3freq);
      end
      for (int i = 1; i <= 40; i++) begin
         cyc();
         exp_f = 10'(1010 - i / 4);
         exp_a = (i == 40);
         n_checks++;
         if ({m3freq, at_speed} !== {exp_f, exp_a}) begin
            n_fail++; $display("FAIL clamp_low cyc %0d: got %0d/%b want %0d/%b", i, m3freq, at_speed, exp_f, exp_a);
         end
      end
      cyc();
      n_checks++;
      if ({m3freq, state_o} !== {10'd1000, 3'd2}) begin
         n_fail++; $display("FAIL clamp_hold: got %0d/%0d want 1000/2", m3freq, state_o);
      end
      send(1'b1, 1'b0, 10'd1023);
      for (int i = 1; i <= 92; i++) begin
         cyc();
         exp_f = 10'(1000 + i / 4);
         exp_a = (i == 92);
         n_checks++;
         if ({m3freq, at_speed} !== {exp_f, exp_a}) begin
            n_fail++; $display("FAIL ramp_up cyc %0d: got %0d/%b want %0d/%b", i, m3freq, at_speed, exp_f, exp_a);
         end
      end
      send(1'b1, 1'b0, 10'd1010);
      repeat (52) cyc();
      n_checks++;
      if ({m3freq, state_o} !== {10'd1010, 3'd2}) begin
         n_fail++; $display("FAIL ramp_down_1010: got %0d/%0d want 1010/2", m3freq, state_o);
      end
   endtask

   task automatic test_reverse();
      logic [15:0] e;
      logic [15:0] got;
      logic        prev_start;
      logic        prev_inv;
      send(1'b1, 1'b1, 10'd1010);
      prev_start = m3start;
      prev_inv   = m3invOrStop;
      for (int i = 1; i <= 112; i++) begin
         cyc();
         if (i < 52) begin
            e = {1'b1, 1'b0, 10'(1010 + i / 4), 3'd3, 1'b0};
         end else if (i < 60) begin
            e = {1'b0, 1'b0, 10'd1023, 3'd4, 1'b0};
         end else begin
            e = {1'b1, 1'b1, 10'(1023 - (i - 60) / 4), (i == 112) ? 3'd2 : 3'd1, 1'b1};
         end
         got = {m3start, m3invOrStop, m3freq, state_o, cmd_if.cmd_ready};
         n_checks++;
         if (got !== e) begin
            n_fail++; $display("FAIL reverse cyc %0d: got %h want %h", i, got, e);
         end
         if (prev_start && m3start) begin
            n_checks++;
            if (m3invOrStop !== prev_inv) begin
               n_fail++; $display("FAIL dir_flip_energised cyc %0d: got %b want %b", i, m3invOrStop, prev_inv);
            end
         end
         prev_start = m3start;
         prev_inv   = m3invOrStop;
      end
   endtask

   task automatic test_stop();
      logic [15:0] e;
      logic [15:0] got;
      send(1'b0, 1'b1, 10'd1010);
      for (int i = 1; i <= 52; i++) begin
         cyc();
         if (i < 52) begin
            e = {1'b1, 1'b1, 10'(1010 + i / 4), 3'd3, 1'b0};
         end else begin
            e = {1'b0, 1'b0, 10'd1023, 3'd0, 1'b1};
         end
         got = {m3start, busy, m3freq, state_o, cmd_if.cmd_ready};
         n_checks++;
         if (got !== e) begin
            n_fail++; $display("FAIL stop cyc %0d: got %h want %h", i, got, e);
         end
      end
   endtask

   task automatic test_fault();
      send(1'b1, 1'b0, 10'd1000);
      repeat (10) cyc();
      n_checks++;
      if ({m3freq, state_o} !== {10'd1021, 3'd1}) begin
         n_fail++; $display("FAIL fault_pre: got %0d/%0d want 1021/1", m3freq, state_o);
      end
      fault = 1'b1;
      cmd_if.cmd_valid = 1'b1; cmd_if.cmd_run = 1'b1; cmd_if.cmd_dir = 1'b1; cmd_if.cmd_code = 10'd1010;
      #1;
      n_checks++;
      if (cmd_if.cmd_ready !== 1'b0) begin
         n_fail++; $display("FAIL fault_ready: got %b want 0", cmd_if.cmd_ready);
      end
      cyc();
      fault = 1'b0;
      n_checks++;
      if ({m3start, m3freq, state_o, fault_latched} !== {1'b0, 10'd1023, 3'd0, 1'b1}) begin
         n_fail++; $display("FAIL fault_trip: got %b %0d %0d %b want 0 1023 0 1", m3start, m3freq, state_o, fault_latched);
      end
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (cmd_if.cmd_ready !== 1'b0) begin
            n_fail++; $display("FAIL latched_ready %0d: got %b want 0", i, cmd_if.cmd_ready);
         end
         cyc();
         n_checks++;
         if ({m3start, state_o, fault_latched} !== {1'b0, 3'd0, 1'b1}) begin
            n_fail++; $display("FAIL latched_hold %0d: got %b %0d %b want 0 0 1", i, m3start, state_o, fault_latched);
         end
      end
      cmd_if.cmd_valid = 1'b0;
      fault = 1'b1; fault_clr = 1'b1;
      cyc();
      n_checks++;
      if (fault_latched !== 1'b1) begin
         n_fail++; $display("FAIL clr_while_fault: got %b want 1", fault_latched);
      end
      fault = 1'b0;
      cyc();
      fault_clr = 1'b0;
      #1;
      n_checks++;
      if ({fault_latched, cmd_if.cmd_ready} !== {1'b0, 1'b1}) begin
         n_fail++; $display("FAIL fault_clear: got %b%b want 01", fault_latched, cmd_if.cmd_ready);
      end
   endtask

   task automatic test_reset_mid_decel();
      logic [17:0] got;
      send(1'b1, 1'b0, 10'd1000);
      repeat (92) cyc();
      n_checks++;
      if ({m3freq, state_o} !== {10'd1000, 3'd2}) begin
         n_fail++; $display("FAIL run_1000: got %0d/%0d want 1000/2", m3freq, state_o);
      end
      send(1'b0, 1'b0, 10'd1000);
      repeat (10) cyc();
      n_checks++;
      if ({m3freq, state_o} !== {10'd1002, 3'd3}) begin
         n_fail++; $display("FAIL mid_decel: got %0d/%0d want 1002/3", m3freq, state_o);
      end
      rst = 1'b1;
      #1;
      n_checks++;
      if (cmd_if.cmd_ready !== 1'b0) begin
         n_fail++; $display("FAIL rst_ready: got %b want 0", cmd_if.cmd_ready);
      end
      cyc();
      rst = 1'b0;
      got = {m3start, m3invOrStop, m3freq, at_speed, busy, fault_latched, state_o};
      n_checks++;
      if (got !== {1'b0, 1'b0, 10'd1023, 1'b0, 1'b0, 1'b0, 3'd0}) begin
         n_fail++; $display("FAIL rst_mid_decel: got %h want %h", got, {1'b0, 1'b0, 10'd1023, 1'b0, 1'b0, 1'b0, 3'd0});
      end
      send(1'b1, 1'b1, 10'd1020);
      n_checks++;
      if ({m3start, m3invOrStop, m3freq, state_o} !== {1'b1, 1'b1, 10'd1023, 3'd1}) begin
         n_fail++; $display("FAIL restart: got %b %b %0d %0d want 1 1 1023 1", m3start, m3invOrStop, m3freq, state_o);
      end
      repeat (6) cyc();
      n_checks++;
      if (m3freq !== 10'd1022) begin
         n_fail++; $display("FAIL restart_ramp: got %0d want 1022", m3freq);
      end
      send(1'b0, 1'b1, 10'd1020);
      n_checks++;
      if ({m3start, m3freq, state_o} !== {1'b1, 10'd1022, 3'd3}) begin
         n_fail++; $display("FAIL accel_divert: got %b %0d %0d want 1 1022 3", m3start, m3freq, state_o);
      end
      repeat (3) cyc();
      n_checks++;
      if ({m3freq, state_o} !== {10'd1022, 3'd3}) begin
         n_fail++; $display("FAIL divert_wait: got %0d/%0d want 1022/3", m3freq, state_o);
      end
      cyc();
      n_checks++;
      if ({m3start, m3freq, state_o, busy} !== {1'b0, 10'd1023, 3'd0, 1'b0}) begin
         n_fail++; $display("FAIL divert_idle: got %b %0d %0d %b want 0 1023 0 0", m3start, m3freq, state_o, busy);
      end
   endtask

   initial begin
      test_reset();
      test_accel();
      test_clamp();
      test_reverse();
      test_stop();
      test_fault();
      test_reset_mid_decel();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
